// File: rtl/tl_instruction_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tl_instruction_fetch
//
// MIPS instruction-fetch stage. Holds the program counter, owns the
// instruction memory and drives the IF/ID pipeline register. A taken branch
// from the execute stage redirects the PC and flushes the wrong-path fetch.
// Fetch stops when the HALT word is fetched; only a branch redirect restarts it.
// The debug unit loads the program through a write port that works at any
// time, independent of enable, stall and halt state.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_reset        asynchronous active-high reset
//   i_enable       run/step enable; when low only memory writes happen
//   i_stall        hazard stall: freeze PC and IF/ID
//   i_PCSrc        branch taken (highest priority)
//   i_add_execute  branch target byte address (low two bits dropped)
//   i_prog_we      instruction-memory write enable
//   i_prog_addr    instruction-memory write word address
//   i_prog_data    instruction-memory write data
//   o_instruction  IF/ID instruction (zero = NOP when flushed)
//   o_adder_if     IF/ID PC+4 of that instruction
//   o_pc           current PC, for debug readout
//   o_valid        o_instruction is a real fetch
//   o_halt         fetch stopped on HALT_WORD
// -----------------------------------------------------------------------------
module tl_instruction_fetch #(
    parameter int             len       = 32,
    parameter int             NB_ADDR   = 10,
    parameter logic [len-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_PCSrc,
    input  logic [len-1:0]     i_add_execute,
    input  logic               i_prog_we,
    input  logic [NB_ADDR-1:0] i_prog_addr,
    input  logic [len-1:0]     i_prog_data,
    output logic [len-1:0]     o_instruction,
    output logic [len-1:0]     o_adder_if,
    output logic [len-1:0]     o_pc,
    output logic               o_valid,
    output logic               o_halt
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t         state_q, state_d;
    logic [len-1:0] pc_q, pc_d;
    logic [len-1:0] instr_q, instr_d;
    logic [len-1:0] adder_q, adder_d;
    logic           valid_q, valid_d;
    logic           halt_q, halt_d;

    logic [len-1:0]     mem [2**NB_ADDR];
    logic [NB_ADDR-1:0] rd_addr;
    logic [len-1:0]     fetch_word;
    logic [len-1:0]     pc_plus4;

    // Branch targets are word aligned; the byte offset bits are discarded.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^i_add_execute[1:0];

    // Word index wraps naturally modulo 2^NB_ADDR by taking only these bits.
    assign rd_addr    = pc_q[NB_ADDR+1:2];
    assign fetch_word = mem[rd_addr];
    assign pc_plus4   = pc_q + len'(4);

    // NOTE: the array has no reset branch - clearing it would prevent RAM
    // inference, and the program survives a pipeline reset by design. The
    // IF/ID register samples fetch_word on the same edge as this write, so a
    // same-address read sees the old word.
    always_ff @(posedge i_clk) begin
        if (i_prog_we) begin
            mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no branch
        // below can leave a signal unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adder_d = adder_q;
        valid_d = valid_q;
        halt_d  = halt_q;

        if (i_enable) begin
            if (i_PCSrc) begin
                // Redirect wins over stall and halt: drop the wrong-path
                // fetch and restart at the target. o_adder_if keeps its value.
                pc_d    = {i_add_execute[len-1:2], 2'b00};
                instr_d = '0;
                valid_d = 1'b0;
                state_d = ST_RUN;
                halt_d  = 1'b0;
            end else if (state_q == ST_HALTED) begin
                instr_d = '0;
                valid_d = 1'b0;
            end else if (!i_stall) begin
                instr_d = fetch_word;
                adder_d = pc_plus4;
                valid_d = 1'b1;
                if (fetch_word == HALT_WORD) begin
                    // The HALT word itself is emitted once; PC parks on it.
                    state_d = ST_HALTED;
                    halt_d  = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            adder_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adder_q <= adder_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_adder_if    = adder_q;
    assign o_pc          = pc_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;

endmodule

// File: tb/tb_tl_instruction_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tl_instruction_fetch
//
// Directed scenarios for fetch, flush, stall, halt, enable, reset and
// read-first memory behaviour, a randomized run against a behavioural model,
// and a wrap-around scenario on a second instance with a 16-word memory.
// -----------------------------------------------------------------------------
module tb_tl_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, stall = 1'b0, pcsrc = 1'b0, we = 1'b0;
    logic [31:0] tgt = '0, wdata = '0;
    logic [9:0]  waddr = '0;
    logic [31:0] o_instruction, o_adder_if, o_pc;
    logic        o_valid, o_halt;

    // Second instance with a 16-word memory for the wrap-around scenario.
    logic        w_en = 1'b0, w_stall = 1'b0, w_pcsrc = 1'b0, w_we = 1'b0;
    logic [31:0] w_tgt = '0, w_wdata = '0;
    logic [3:0]  w_waddr = '0;
    logic [31:0] w_instruction, w_adder_if, w_pc;
    logic        w_valid, w_halt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tl_instruction_fetch dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall),
        .i_PCSrc(pcsrc), .i_add_execute(tgt), .i_prog_we(we),
        .i_prog_addr(waddr), .i_prog_data(wdata),
        .o_instruction(o_instruction), .o_adder_if(o_adder_if), .o_pc(o_pc),
        .o_valid(o_valid), .o_halt(o_halt)
    );

    tl_instruction_fetch #(.NB_ADDR(4)) dut_w (
        .i_clk(clk), .i_reset(rst), .i_enable(w_en), .i_stall(w_stall),
        .i_PCSrc(w_pcsrc), .i_add_execute(w_tgt), .i_prog_we(w_we),
        .i_prog_addr(w_waddr), .i_prog_data(w_wdata),
        .o_instruction(w_instruction), .o_adder_if(w_adder_if), .o_pc(w_pc),
        .o_valid(w_valid), .o_halt(w_halt)
    );

    // Observed output tuple: {instruction, adder, pc, valid, halt}.
    logic [97:0] obs, wobs;
    assign obs  = {o_instruction, o_adder_if, o_pc, o_valid, o_halt};
    assign wobs = {w_instruction, w_adder_if, w_pc, w_valid, w_halt};

    // ---------------- behavioural model of the main instance ----------------
    logic [31:0] mref [1024];
    logic [31:0] m_pc, m_instr, m_adder;
    logic        m_valid, m_halted;

    task automatic model_reset();
        m_pc = '0; m_instr = '0; m_adder = '0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] word;
        word = mref[m_pc[11:2]];
        if (en) begin
            if (pcsrc) begin
                m_pc = tgt & ~32'h3; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
            end else if (m_halted) begin
                m_instr = '0; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = word; m_adder = m_pc + 32'd4; m_valid = 1'b1;
                if (word === HALT) m_halted = 1'b1;
                else               m_pc = m_pc + 32'd4;
            end
        end
        if (we) mref[waddr] = wdata;
    endtask

    // One clock: the model advances on the same edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic prog(input logic [9:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic restart();
        en = 1'b0; stall = 1'b0; pcsrc = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------- scenarios -------------------------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 98'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, 98'd0);
        end
        prog(10'd0, 32'h20010005);
        prog(10'd1, 32'h20020007);
        prog(10'd2, 32'h00221820);
        prog(10'd3, HALT);
        prog(10'd16, 32'hA5A50001);
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        logic [31:0] e_i [5] = '{32'h20010005, 32'h20020007, 32'h00221820, HALT, 32'h0};
        logic [31:0] e_a [5] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd16};
        logic [31:0] e_p [5] = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
        logic        e_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        e_h [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        restart();
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            int j;
            j = (k > 4) ? 4 : k;
            tick();
            checks++;
            if (obs !== {e_i[j], e_a[j], e_p[j], e_v[j], e_h[j]}) begin
                errors++;
                $display("FAIL straight[%0d]: got %h want %h", k, obs,
                         {e_i[j], e_a[j], e_p[j], e_v[j], e_h[j]});
            end
        end
        en = 1'b0;
    endtask

    task automatic test_branch_flush();
        restart();
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== {32'h20020007, 32'd8, 32'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL branch_pre: got %h", obs);
        end
        pcsrc = 1'b1; tgt = 32'h43;
        tick();
        checks++;
        if (obs !== {32'h0, 32'd8, 32'h40, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL branch_flush: got %h want %h", obs, {32'h0, 32'd8, 32'h40, 1'b0, 1'b0});
        end
        pcsrc = 1'b0;
        tick();
        checks++;
        if (obs !== {32'hA5A50001, 32'h44, 32'h44, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL branch_target_fetch: got %h want %h", obs,
                     {32'hA5A50001, 32'h44, 32'h44, 1'b1, 1'b0});
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        restart();
        en = 1'b1;
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs !== {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", k, obs,
                         {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0});
            end
        end
        pcsrc = 1'b1; tgt = 32'h20;
        tick();
        checks++;
        if (obs !== {32'h0, 32'd4, 32'h20, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stall_and_branch: got %h want %h", obs, {32'h0, 32'd4, 32'h20, 1'b0, 1'b0});
        end
        stall = 1'b0; pcsrc = 1'b0; en = 1'b0;
    endtask

    task automatic test_halt_recovery();
        restart();
        en = 1'b1;
        repeat (4) tick();
        stall = 1'b1;
        tick();
        checks++;
        if (obs !== {32'h0, 32'd16, 32'd12, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL halted_idle: got %h want %h", obs, {32'h0, 32'd16, 32'd12, 1'b0, 1'b1});
        end
        stall = 1'b0; pcsrc = 1'b1; tgt = 32'h0;
        tick();
        checks++;
        if (obs !== {32'h0, 32'd16, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_redirect: got %h want %h", obs, {32'h0, 32'd16, 32'd0, 1'b0, 1'b0});
        end
        pcsrc = 1'b0;
        tick();
        checks++;
        if (obs !== {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_resume: got %h want %h", obs, {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_enable_hold();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pcsrc = 1'($urandom); stall = 1'($urandom); tgt = $urandom;
            tick();
            checks++;
            if (obs !== {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got %h", k, obs);
            end
        end
        pcsrc = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset_midrun();
        en = 1'b1;
        tick();
        checks++;
        if (obs !== {32'h20020007, 32'd8, 32'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midrun_pre: got %h", obs);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 98'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL after_reset_fetch: got %h want %h", obs, {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_read_first();
        pcsrc = 1'b1; tgt = 32'h0;
        tick();
        pcsrc = 1'b0;
        we = 1'b1; waddr = 10'd0; wdata = 32'h11111111;
        tick();
        we = 1'b0;
        checks++;
        if (obs !== {32'h20010005, 32'd4, 32'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_first_old: got %h", obs);
        end
        pcsrc = 1'b1;
        tick();
        pcsrc = 1'b0;
        tick();
        checks++;
        if (obs !== {32'h11111111, 32'd4, 32'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_first_new: got %h", obs);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        logic [97:0] exp_v;
        restart();
        for (int a = 0; a < 1024; a++) begin
            prog(10'(a), ($urandom_range(0, 31) == 0) ? HALT : $urandom);
        end
        for (int k = 0; k < 3000; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            pcsrc = ($urandom_range(0, 9) == 0);
            tgt   = $urandom;
            we    = ($urandom_range(0, 9) == 0);
            waddr = 10'($urandom);
            wdata = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            tick();
            exp_v = {m_instr, m_adder, m_pc, m_valid, m_halted};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", k, obs, exp_v);
            end
        end
        en = 1'b0; stall = 1'b0; pcsrc = 1'b0; we = 1'b0;
    endtask

    task automatic test_wrap();
        w_we = 1'b1; w_waddr = 4'd15; w_wdata = 32'hF0F0000F;
        tick();
        w_waddr = 4'd0; w_wdata = 32'h0A0A0000;
        tick();
        w_we = 1'b0;
        w_en = 1'b1; w_pcsrc = 1'b1; w_tgt = 32'd60;
        tick();
        w_pcsrc = 1'b0;
        checks++;
        if (w_pc !== 32'd60 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_redirect: got pc=%h valid=%b want 3c 0", w_pc, w_valid);
        end
        tick();
        checks++;
        if (wobs !== {32'hF0F0000F, 32'd64, 32'd64, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_last_word: got %h", wobs);
        end
        tick();
        checks++;
        if (wobs !== {32'h0A0A0000, 32'd68, 32'd68, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_word0: got %h", wobs);
        end
        w_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_branch_flush();
        test_stall();
        test_halt_recovery();
        test_enable_hold();
        test_reset_midrun();
        test_read_first();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
